// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Holds the state encoding, reset-value constants and the load-use hazard test.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_WAIT_MC = 2'd1,
    PC_REDIR   = 2'd2
  } pc_state_e;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG     = 5'd0;
  localparam logic        HOLD_ENABLE  = 1'b1;
  localparam logic        HOLD_DISABLE = 1'b0;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  function automatic logic load_use_hazard(
    input logic       is_load,
    input logic       reg_wen,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return is_load && reg_wen && (rd != ZERO_REG) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating event counter used for the optional performance counters.
// Only compiled in when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Stall/flush arbiter for the 3-stage core: jump redirect, multi-cycle wait, load-use and fetch wait.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_reg_wen_i,
  input  logic             ex_is_load_i,
  input  logic             mc_req_i,
  input  logic             mc_done_i,
  input  logic             bus_wait_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic             mc_timeout_o
);

  localparam int                WCNT_W   = $clog2(MC_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] CNT_LAST = WCNT_W'(MC_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] CNT_MAX  = {WCNT_W{1'b1}};

  pc_state_e         r_state;
  pc_state_e         w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_cnt_nxt;
  logic              r_jump_pend;
  logic              w_jump_pend_nxt;
  logic [31:0]       r_jump_addr;
  logic [31:0]       w_jump_addr_nxt;

  logic              w_hold_pc;
  logic              w_hold_if_id;
  logic              w_hold_id_ex;
  logic              w_flush_if_id;
  logic              w_flush_id_ex;
  logic              w_jump_en;
  logic [31:0]       w_jump_addr;
  logic              w_timeout;
  logic              w_load_use;
  logic              w_mc_exit;

  assign w_load_use = load_use_hazard(ex_is_load_i, ex_reg_wen_i, ex_rd_addr_i,
                                      id_rs1_addr_i, id_rs2_addr_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= PC_RUN;
      r_wait_cnt  <= '0;
      r_jump_pend <= 1'b0;
      r_jump_addr <= ZERO_WORD;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_jump_pend <= w_jump_pend_nxt;
      r_jump_addr <= w_jump_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_jump_pend_nxt = r_jump_pend;
    w_jump_addr_nxt = r_jump_addr;
    w_hold_pc       = HOLD_DISABLE;
    w_hold_if_id    = HOLD_DISABLE;
    w_hold_id_ex    = HOLD_DISABLE;
    w_flush_if_id   = 1'b0;
    w_flush_id_ex   = 1'b0;
    w_jump_en       = 1'b0;
    w_jump_addr     = ZERO_WORD;
    w_timeout       = 1'b0;
    w_mc_exit       = 1'b0;

    case (r_state)
      PC_RUN: begin
        if (jump_en_i) begin
          w_jump_en     = 1'b1;
          w_jump_addr   = jump_addr_i;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (mc_req_i) begin
          w_hold_pc      = HOLD_ENABLE;
          w_hold_if_id   = HOLD_ENABLE;
          w_hold_id_ex   = HOLD_ENABLE;
          w_state_nxt    = PC_WAIT_MC;
          w_wait_cnt_nxt = WCNT_W'(1);
        end else if (w_load_use || bus_wait_i) begin
          w_hold_pc     = HOLD_ENABLE;
          w_hold_if_id  = HOLD_ENABLE;
          w_flush_id_ex = 1'b1;
        end
      end

      PC_WAIT_MC: begin
        // A jump resolved while stalled is replayed one cycle after the wait ends.
        if (jump_en_i) begin
          w_jump_pend_nxt = 1'b1;
          w_jump_addr_nxt = jump_addr_i;
        end
        w_mc_exit = mc_done_i || (r_wait_cnt == CNT_LAST);
        if (w_mc_exit) begin
          w_timeout      = !mc_done_i;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = w_jump_pend_nxt ? PC_REDIR : PC_RUN;
        end else begin
          w_hold_pc      = HOLD_ENABLE;
          w_hold_if_id   = HOLD_ENABLE;
          w_hold_id_ex   = HOLD_ENABLE;
          w_wait_cnt_nxt = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + WCNT_W'(1);
        end
      end

      PC_REDIR: begin
        w_jump_en       = 1'b1;
        w_jump_addr     = r_jump_addr;
        w_flush_if_id   = 1'b1;
        w_flush_id_ex   = 1'b1;
        w_jump_pend_nxt = 1'b0;
        w_jump_addr_nxt = ZERO_WORD;
        w_state_nxt     = PC_RUN;
      end

      default: begin
        w_state_nxt = PC_RUN;
      end
    endcase
  end

  // Outputs are forced quiet while reset is low; a flush always beats a hold on the same stage.
  always_comb begin
    hold_pc_o     = rst & w_hold_pc;
    hold_if_id_o  = rst & w_hold_if_id & ~w_flush_if_id;
    hold_id_ex_o  = rst & w_hold_id_ex & ~w_flush_id_ex;
    flush_if_id_o = rst & w_flush_if_id;
    flush_id_ex_o = rst & w_flush_id_ex;
    jump_en_o     = rst & w_jump_en;
    jump_addr_o   = (rst && w_jump_en) ? w_jump_addr : ZERO_WORD;
    mc_timeout_o  = rst & w_timeout;
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hold_pc_o),
    .cnt_o (stall_cnt_o)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (jump_en_o),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int MC_TIMEOUT = 8;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_reg_wen_i;
  logic        ex_is_load_i;
  logic        mc_req_i;
  logic        mc_done_i;
  logic        bus_wait_i;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        mc_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MC_TIMEOUT(MC_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_reg_wen_i  (ex_reg_wen_i),
    .ex_is_load_i  (ex_is_load_i),
    .mc_req_i      (mc_req_i),
    .mc_done_i     (mc_done_i),
    .bus_wait_i    (bus_wait_i),
    .hold_pc_o     (hold_pc_o),
    .hold_if_id_o  (hold_if_id_o),
    .hold_id_ex_o  (hold_id_ex_o),
    .flush_if_id_o (flush_if_id_o),
    .flush_id_ex_o (flush_id_ex_o),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt_o   (stallCnt),
    .flush_cnt_o   (flushCnt),
`endif
    .mc_timeout_o  (mc_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_en, timeout}
  function automatic logic [6:0] outVec();
    return {hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
            jump_en_o, mc_timeout_o};
  endfunction

  task automatic applyStimulus(
    input bit          jmp,
    input logic [31:0] addr,
    input bit          req,
    input bit          done,
    input bit          bw,
    input bit          ld,
    input bit          wen,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2
  );
    @(posedge clk);
    #1;
    jump_en_i     = jmp;
    jump_addr_i   = addr;
    mc_req_i      = req;
    mc_done_i     = done;
    bus_wait_i    = bw;
    ex_is_load_i  = ld;
    ex_reg_wen_i  = wen;
    ex_rd_addr_i  = rd;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expVec,
                             input logic [31:0] expAddr);
    checks++;
    if (outVec() !== expVec) begin
      errors++;
      $display("[TB] FAIL %s: outputs got %b expected %b at %0t", name, outVec(), expVec, $time);
    end
    if (expVec[1]) begin
      checks++;
      if (jump_addr_o !== expAddr) begin
        errors++;
        $display("[TB] FAIL %s addr: got %h expected %h at %0t", name, jump_addr_o, expAddr, $time);
      end
    end
  endtask

  // Behavioural model: tracks "inside a multi-cycle wait", elapsed wait cycles,
  // a remembered jump and whether the replayed redirect is due this cycle.
  bit          mInMc;
  int          mCycles;
  bit          mPend;
  logic [31:0] mPendAddr;
  bit          mRedir;

  initial begin
    logic [6:0]  expVec;
    logic [31:0] expAddr;
    bit          hazard;
    mInMc = 0; mCycles = 0; mPend = 0; mPendAddr = '0; mRedir = 0;
    forever begin
      @(negedge clk);
      expVec  = '0;
      expAddr = '0;
      hazard  = ex_is_load_i && ex_reg_wen_i && (ex_rd_addr_i != 0) &&
                (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
      if (!rst) begin
        mInMc = 0; mCycles = 0; mPend = 0; mRedir = 0;
      end else if (mRedir) begin
        expVec  = 7'b0001110;
        expAddr = mPendAddr;
        mRedir  = 0;
        mPend   = 0;
      end else if (mInMc) begin
        if (jump_en_i) begin
          mPend     = 1;
          mPendAddr = jump_addr_i;
        end
        if (mc_done_i || mCycles == MC_TIMEOUT - 1) begin
          expVec = mc_done_i ? 7'b0000000 : 7'b0000001;
          mInMc  = 0;
          mRedir = mPend;
        end else begin
          expVec  = 7'b1110000;
          mCycles = mCycles + 1;
        end
      end else if (jump_en_i) begin
        expVec  = 7'b0001110;
        expAddr = jump_addr_i;
      end else if (mc_req_i) begin
        expVec  = 7'b1110000;
        mInMc   = 1;
        mCycles = 1;
      end else if (hazard || bus_wait_i) begin
        expVec = 7'b1100100;
      end
      checkOutput("model", expVec, expAddr);
    end
  end

  initial begin
    rst = 1'b0;
    jump_en_i = 1'b1; jump_addr_i = 32'hDEAD_BEEF; mc_req_i = 1'b1; mc_done_i = 1'b0;
    bus_wait_i = 1'b1; ex_is_load_i = 1'b0; ex_reg_wen_i = 1'b0;
    ex_rd_addr_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;

    @(negedge clk);
    checkOutput("reset_quiet", 7'b0000000, 32'h0);
    jump_en_i = 1'b0; jump_addr_i = '0; mc_req_i = 1'b0; bus_wait_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Load-use on rs2, then a load into x0 that must not stall
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 1, 5'd5, 5'd3, 5'd5);
    @(negedge clk); checkOutput("load_use_rs2", 7'b1100100, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("load_x0", 7'b0000000, 32'h0);

    // Jump beats a simultaneous multi-cycle request
    applyStimulus(1, 32'h100, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("jump_over_mc", 7'b0001110, 32'h100);
    idle();
    @(negedge clk); checkOutput("after_jump", 7'b0000000, 32'h0);

    // Multi-cycle op finishing after three stalled cycles
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("mc_req", 7'b1110000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk); checkOutput("mc_wait", 7'b1110000, 32'h0);
    end
    applyStimulus(0, 32'h0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("mc_done", 7'b0000000, 32'h0);
    idle();
    @(negedge clk); checkOutput("mc_back_run", 7'b0000000, 32'h0);

    // Jump during the wait is replayed after done
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("redir_req", 7'b1110000, 32'h0);
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("redir_latch", 7'b1110000, 32'h0);
    idle();
    @(negedge clk); checkOutput("redir_wait", 7'b1110000, 32'h0);
    applyStimulus(0, 32'h0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("redir_done", 7'b0000000, 32'h0);
    idle();
    @(negedge clk); checkOutput("redir_fire", 7'b0001110, 32'h80);
    idle();
    @(negedge clk); checkOutput("redir_after", 7'b0000000, 32'h0);

    // Timeout: request cycle plus MC_TIMEOUT-2 held cycles, pulse on the next
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); checkOutput("to_req", 7'b1110000, 32'h0);
    for (int i = 0; i < MC_TIMEOUT - 2; i++) begin
      idle();
      @(negedge clk); checkOutput("to_wait", 7'b1110000, 32'h0);
    end
    idle();
    @(negedge clk); checkOutput("to_pulse", 7'b0000001, 32'h0);
    idle();
    @(negedge clk); checkOutput("to_after", 7'b0000000, 32'h0);

    // Asynchronous reset while mid-wait with counter at 5
    applyStimulus(0, 32'h0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) idle();
    @(negedge clk); checkOutput("pre_reset_hold", 7'b1110000, 32'h0);
    idle();
    rst = 1'b0;
    #1 checkOutput("async_reset", 7'b0000000, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); checkOutput("reset_run", 7'b0000000, 32'h0);

    // Randomized traffic; small register range makes hazards frequent
    for (int n = 0; n < 4000; n++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)));
      rst = ($urandom_range(0, 249) != 0);
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
